// File: rtl/mmio_pkg.sv
// Shared encodings for the host mailbox bridge:
// mem_op codes, the core address map and the host FSM states.
package mmio_pkg;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  localparam logic [1:0] ADDR_RD_DATA = 2'd0;
  localparam logic [1:0] ADDR_RD_VLD  = 2'd1;
  localparam logic [1:0] ADDR_WR_DATA = 2'd2;
  localparam logic [1:0] ADDR_WR_STS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER_RD,
    ST_XFER_WR,
    ST_GAP
  } host_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact occupancy count.
// Head is combinational from the read pointer.
module sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = $clog2(FIFO_DEPTH),
  parameter int CW         = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_host_bridge.sv
// Host transfer engine behind the core mailbox map:
// RX FIFO filled by host reads, TX FIFO drained by host writes.
module mmio_host_bridge
  import mmio_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          core_re,
  input  logic                          core_we,
  input  logic [1:0]                    core_addr,
  input  logic [DATA_W-1:0]             core_wdata,
  output logic [DATA_W-1:0]             core_rdata,
  input  logic                          host_ready,
  input  logic                          host_tx_done,
  input  logic [DATA_W-1:0]             host_rd_data,
  output logic [DATA_W-1:0]             host_wr_data,
  output logic [1:0]                    mem_op,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count
);

  host_state_t state;
  logic [1:0]  last_op;
  logic        overflow;

  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] rx_head, tx_head;
  logic              rd_ok, wr_ok;
  logic              wr_data_hit;

  assign wr_data_hit = core_we && (core_addr == ADDR_WR_DATA);
  assign rx_push = (state == ST_XFER_RD) && host_tx_done;
  assign rx_pop  = core_re && (core_addr == ADDR_RD_DATA) && !rx_empty;
  assign tx_push = wr_data_hit && !tx_full;
  assign tx_pop  = (state == ST_XFER_WR) && host_tx_done;
  assign rd_ok   = !rx_full;
  assign wr_ok   = !tx_empty;

  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (host_rd_data),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (core_wdata),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdata <= '0;
      overflow   <= 1'b0;
    end else begin
      if (core_re) begin
        unique case (core_addr)
          ADDR_RD_DATA: core_rdata <= rx_empty ? '0 : rx_head;
          ADDR_RD_VLD:  core_rdata <= DATA_W'(!rx_empty);
          ADDR_WR_DATA: core_rdata <= '0;
          ADDR_WR_STS:  core_rdata <= DATA_W'({overflow, tx_full});
        endcase
      end
      // full is judged before any same-cycle host pop
      if (wr_data_hit && tx_full)
        overflow <= 1'b1;
      else if (core_we && (core_addr == ADDR_WR_STS))
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      mem_op       <= MEM_IDLE;
      host_wr_data <= '0;
      last_op      <= MEM_WRITE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (host_ready) begin
            if (rd_ok && (!wr_ok || last_op == MEM_WRITE)) begin
              state  <= ST_XFER_RD;
              mem_op <= MEM_READ;
            end else if (wr_ok) begin
              state        <= ST_XFER_WR;
              mem_op       <= MEM_WRITE;
              host_wr_data <= tx_head;
            end
          end
        end
        ST_XFER_RD: begin
          if (host_tx_done) begin
            state   <= ST_GAP;
            mem_op  <= MEM_IDLE;
            last_op <= MEM_READ;
          end
        end
        ST_XFER_WR: begin
          if (host_tx_done) begin
            state   <= ST_GAP;
            mem_op  <= MEM_IDLE;
            last_op <= MEM_WRITE;
          end
        end
        ST_GAP: begin
          state  <= ST_IDLE;
          mem_op <= MEM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_host_bridge.sv
// Directed self-checking bench for mmio_host_bridge.
// Each task drives one scenario and compares against hand-computed values.
module tb_mmio_host_bridge;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              core_re = 1'b0;
  logic              core_we = 1'b0;
  logic [1:0]        core_addr = 2'd0;
  logic [DATA_W-1:0] core_wdata = '0;
  logic [DATA_W-1:0] core_rdata;
  logic              host_ready = 1'b0;
  logic              host_tx_done = 1'b0;
  logic [DATA_W-1:0] host_rd_data = '0;
  logic [DATA_W-1:0] host_wr_data;
  logic [1:0]        mem_op;
  logic [2:0]        rx_count;
  logic [2:0]        tx_count;

  int checks = 0;
  int fails  = 0;

  mmio_host_bridge #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_re      (core_re),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .host_ready   (host_ready),
    .host_tx_done (host_tx_done),
    .host_rd_data (host_rd_data),
    .host_wr_data (host_wr_data),
    .mem_op       (mem_op),
    .rx_count     (rx_count),
    .tx_count     (tx_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_read(input logic [1:0] a, output logic [DATA_W-1:0] d);
    core_addr = a;
    core_re   = 1'b1;
    tick();
    core_re = 1'b0;
    d = core_rdata;
  endtask

  task automatic core_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
    core_addr  = a;
    core_wdata = d;
    core_we    = 1'b1;
    tick();
    core_we = 1'b0;
  endtask

  task automatic pulse_done(input logic [DATA_W-1:0] d);
    host_rd_data = d;
    host_tx_done = 1'b1;
    tick();
    host_tx_done = 1'b0;
  endtask

  task automatic wait_op(input string name);
    int n = 0;
    while (mem_op == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    if (mem_op == 2'b00) begin
      checks++;
      fails++;
      $display("FAIL %s: timeout, mem_op=%b required non-idle", name, mem_op);
    end
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] d;
    rst = 1'b1;
    #12;
    checks++;
    if (mem_op !== 2'b00 || rx_count !== 3'd0 || tx_count !== 3'd0) begin
      fails++;
      $display("FAIL reset: op=%b rx=%0d tx=%0d required 00/0/0", mem_op, rx_count, tx_count);
    end
    checks++;
    if (core_rdata !== 32'h0 || host_wr_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: rdata=%h wr=%h required 0/0", core_rdata, host_wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_op !== 2'b00) begin
      fails++;
      $display("FAIL idle_no_ready: mem_op=%b required 00", mem_op);
    end
    core_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdvld: got %h required 0", d);
    end
  endtask

  task automatic test_host_read();
    logic [DATA_W-1:0] d;
    host_ready = 1'b1;
    wait_op("host_read_start");
    checks++;
    if (mem_op !== 2'b01) begin
      fails++;
      $display("FAIL host_read_op: mem_op=%b required 01", mem_op);
    end
    host_ready = 1'b0;
    pulse_done(32'hDEADBEEF);
    checks++;
    if (mem_op !== 2'b00 || rx_count !== 3'd1) begin
      fails++;
      $display("FAIL host_read_gap: op=%b rx=%0d required 00/1", mem_op, rx_count);
    end
    core_read(2'd1, d);
    checks++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL rdvld_set: got %h required 1", d);
    end
    core_read(2'd0, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rd_data: got %h required deadbeef", d);
    end
    core_read(2'd0, d);
    checks++;
    if (d !== 32'h0 || rx_count !== 3'd0) begin
      fails++;
      $display("FAIL rd_empty: got %h rx=%0d required 0/0", d, rx_count);
    end
    core_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL rd_addr2: got %h required 0", d);
    end
  endtask

  task automatic test_host_write();
    logic [DATA_W-1:0] d;
    for (int i = 1; i <= 4; i++) begin
      host_ready = 1'b1;
      wait_op("fill_rx");
      host_ready = 1'b0;
      pulse_done(DATA_W'(i));
      tick();
    end
    checks++;
    if (rx_count !== 3'd4) begin
      fails++;
      $display("FAIL rx_fill: rx=%0d required 4", rx_count);
    end
    host_ready = 1'b1;
    core_write(2'd2, 32'h12345678);
    checks++;
    if (tx_count !== 3'd1 || mem_op !== 2'b00) begin
      fails++;
      $display("FAIL wr_n1: tx=%0d op=%b required 1/00", tx_count, mem_op);
    end
    tick();
    checks++;
    if (mem_op !== 2'b11 || host_wr_data !== 32'h12345678) begin
      fails++;
      $display("FAIL wr_n2: op=%b data=%h required 11/12345678", mem_op, host_wr_data);
    end
    host_ready = 1'b0;
    tick();
    checks++;
    if (mem_op !== 2'b11 || host_wr_data !== 32'h12345678) begin
      fails++;
      $display("FAIL wr_hold: op=%b data=%h required 11/12345678", mem_op, host_wr_data);
    end
    pulse_done(32'h0);
    checks++;
    if (tx_count !== 3'd0 || mem_op !== 2'b00) begin
      fails++;
      $display("FAIL wr_done: tx=%0d op=%b required 0/00", tx_count, mem_op);
    end
    for (int i = 1; i <= 4; i++) begin
      core_read(2'd0, d);
      checks++;
      if (d !== DATA_W'(i)) begin
        fails++;
        $display("FAIL rx_order: got %h required %h", d, DATA_W'(i));
      end
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] d;
    host_ready = 1'b0;
    core_write(2'd2, 32'h11);
    core_write(2'd2, 32'h22);
    core_write(2'd2, 32'h33);
    core_write(2'd2, 32'h44);
    core_write(2'd2, 32'hAA);
    checks++;
    if (tx_count !== 3'd4) begin
      fails++;
      $display("FAIL tx_full_cnt: tx=%0d required 4", tx_count);
    end
    core_read(2'd3, d);
    checks++;
    if (d !== 32'h3) begin
      fails++;
      $display("FAIL ovf_status: got %h required 3", d);
    end
    core_write(2'd3, 32'hFFFF_FFFF);
    core_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL ovf_clear: got %h required 1", d);
    end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] wexp [4];
    int wi = 0;
    wexp[0] = 32'h11;
    wexp[1] = 32'h22;
    wexp[2] = 32'h33;
    wexp[3] = 32'h44;
    host_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_op("rr_start");
      checks++;
      if (mem_op !== ((i % 2 == 0) ? 2'b01 : 2'b11)) begin
        fails++;
        $display("FAIL rr_order: txn %0d op=%b", i, mem_op);
      end
      if (mem_op == 2'b11) begin
        checks++;
        if (host_wr_data !== wexp[wi]) begin
          fails++;
          $display("FAIL rr_wdata: got %h required %h", host_wr_data, wexp[wi]);
        end
        wi++;
      end
      pulse_done(32'h100 + DATA_W'(i));
    end
    tick();
    tick();
    host_ready = 1'b0;
    checks++;
    if (tx_count !== 3'd0 || rx_count !== 3'd4 || mem_op !== 2'b00) begin
      fails++;
      $display("FAIL rr_end: tx=%0d rx=%0d op=%b required 0/4/00", tx_count, rx_count, mem_op);
    end
    for (int i = 0; i < 4; i++) begin
      core_read(2'd0, d);
      checks++;
      if (d !== 32'h100 + DATA_W'(2 * i)) begin
        fails++;
        $display("FAIL rr_rxdata: got %h required %h", d, 32'h100 + DATA_W'(2 * i));
      end
    end
  endtask

  task automatic test_reset_mid();
    core_write(2'd2, 32'h55);
    host_ready = 1'b1;
    wait_op("rst_rd");
    checks++;
    if (mem_op !== 2'b01) begin
      fails++;
      $display("FAIL rst_pre_rd: op=%b required 01", mem_op);
    end
    pulse_done(32'h77);
    wait_op("rst_wr");
    checks++;
    if (mem_op !== 2'b11 || host_wr_data !== 32'h55) begin
      fails++;
      $display("FAIL rst_pre_wr: op=%b data=%h required 11/55", mem_op, host_wr_data);
    end
    host_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_op !== 2'b00 || rx_count !== 3'd0 || tx_count !== 3'd0) begin
      fails++;
      $display("FAIL rst_async: op=%b rx=%0d tx=%0d required 00/0/0", mem_op, rx_count, tx_count);
    end
    @(negedge clk);
    rst = 1'b0;
    host_ready = 1'b1;
    wait_op("rst_after");
    checks++;
    if (mem_op !== 2'b01 || tx_count !== 3'd0) begin
      fails++;
      $display("FAIL rst_resend: op=%b tx=%0d required 01/0", mem_op, tx_count);
    end
    host_ready = 1'b0;
    pulse_done(32'h0);
  endtask

  initial begin
    test_reset();
    test_host_read();
    test_host_write();
    test_overflow();
    test_round_robin();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mmio_host_bridge.md
Name: mmio_host_bridge

Overview:
Host-facing transfer engine that feeds and drains the core's memory-mapped host mailbox. Core side: the same 4-word address map as the mailbox, backed by an RX FIFO (host→core words) and a TX FIFO (core→host words). Host side: the block runs the ready / tx_done / mem_op handshake, moving one word per host transaction.

Parameters:
DATA_W, 32, data word width
FIFO_DEPTH, 4, entries per FIFO; power of two, at least 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
core_re  in  1  core read strobe, one cycle
core_we  in  1  core write strobe, one cycle; core_re and core_we are never both high
core_addr  in  2  0 rd data, 1 rd valid, 2 wr data, 3 wr status
core_wdata  in  DATA_W  core write data
core_rdata  out  DATA_W  registered read data
host_ready  in  1  host can accept a transaction
host_tx_done  in  1  host finished the current transaction (one-cycle pulse)
host_rd_data  in  DATA_W  host→core word, valid with host_tx_done on READ
host_wr_data  out  DATA_W  core→host word, valid while mem_op==WRITE
mem_op  out  2  00 IDLE, 01 READ, 11 WRITE
rx_count  out  $clog2(FIFO_DEPTH)+1  RX occupancy
tx_count  out  $clog2(FIFO_DEPTH)+1  TX occupancy

Behaviour:
- Reset (async, rst=1): both FIFOs empty; counts 0; core_rdata 0; host_wr_data 0; mem_op IDLE; FSM in IDLE; last_op=WRITE; overflow flag 0. Reset mid-transaction aborts it; mem_op drops to IDLE with no clock edge needed.
- Core reads: core_rdata updates on the edge after core_re and holds until the next read.
  - addr 0: returns RX head and pops it. If RX is empty, returns 0 and nothing changes.
  - addr 1: returns {0, rx_not_empty}.
  - addr 2: returns 0.
  - addr 3: returns {0, overflow, tx_full}.
- Core writes:
  - addr 2: pushes core_wdata into TX. If TX is full, the word is dropped and the sticky overflow flag is set.
  - addr 3: clears overflow; any data value.
  - addr 0 and addr 1: ignored.
- Host FSM states: IDLE, XFER_RD, XFER_WR, GAP.
  - IDLE: mem_op=IDLE. When host_ready=1:
    - rd_ok = RX not full.
    - wr_ok = TX not empty.
    - Only one true: go to that transfer. Both true: serve the op opposite to last_op (round-robin).
    - Neither true: stay in IDLE.
  - XFER_RD: mem_op=READ. On host_tx_done: push host_rd_data to RX, last_op=READ, go to GAP.
  - XFER_WR: mem_op=WRITE; host_wr_data = TX head, held stable. On host_tx_done: pop TX, last_op=WRITE, go to GAP.
  - GAP: mem_op=IDLE for exactly one cycle, then go to IDLE. This guarantees a visible IDLE between transactions.
- host_tx_done outside XFER states is ignored. host_ready is sampled only in IDLE; dropping it mid-transfer has no effect.
- Simultaneous events:
  - Host push to RX and core pop of RX in the same cycle: both occur; rx_count unchanged.
  - Host pop of TX and core push to TX in the same cycle: both occur. A push into a full TX in that cycle still overflows; full is evaluated before the pop.
- Counts are exact; pointers wrap modulo FIFO_DEPTH.
- Latency:
  - Core write to addr 2 in cycle n gives tx_count+1 at n+1. With host_ready high and RX full, mem_op=WRITE at n+2.
  - Host word gives rd_valid=1 one cycle after host_tx_done.

Decomposition:
- Package mmio_pkg holds:
  - mem_op localparams MEM_IDLE, MEM_READ, MEM_WRITE
  - address localparams ADDR_RD_DATA, ADDR_RD_VLD, ADDR_WR_DATA, ADDR_WR_STS
  - host FSM state enum
- Sub-module sync_fifo (DATA_W, FIFO_DEPTH; push, pop, full, empty, count, head), instantiated twice (RX, TX). Head is combinational from the read pointer.

Test Plan:
- Reset then idle, host_ready=0 -> mem_op=00, rx_count=0, tx_count=0, core read addr1 returns 0.
- Host read: host_ready=1, TX empty -> mem_op=01. Pulse tx_done with host_rd_data=0xDEADBEEF -> GAP cycle shows mem_op=00. Core read addr1 returns 1; addr0 returns 0xDEADBEEF; a second addr0 read returns 0.
- Core write 0x12345678 to addr2 with host_ready=1 and RX full -> mem_op=11 with host_wr_data=0x12345678. After tx_done, tx_count=0.
- Fill TX with 4 writes, then a 5th (0xAA) with host_ready=0 -> addr3 reads 0b11; 0xAA is never sent. Write addr3 -> addr3 reads 0b01.
- Both eligible with last_op=WRITE -> READ served first, then WRITE, alternating across 4 transactions.
- Assert rst while mem_op=11 -> mem_op=00 in the same cycle; after release, FIFOs empty and the word is not resent.
